// File: rtl/phase_gen_pkg.sv
// Shared types and helpers for the multi-lane M-PSK phase generator.
package phase_gen_pkg;

  typedef enum logic [1:0] {LOAD, IDLE, RUN} state_e;

  localparam logic [31:0] DEFAULT_STEP = 32'd916455424;

  // Top out_w bits of an acc_w-wide phase word (acc_w <= 64).
  function automatic logic [63:0] phase_slice(input logic [63:0] acc, input int acc_w,
                                              input int out_w);
    return acc >> (acc_w - out_w);
  endfunction

endpackage

// File: rtl/phase_lane_offs.sv
// Builds offs[i] = i*step and blk = LANES*step with a single adder, one lane per cycle.
module phase_lane_offs #(
  parameter int LANES = 16,
  parameter int ACC_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ACC_W-1:0]            step,
  output logic [LANES-1:0][ACC_W-1:0] offs,
  output logic [ACC_W-1:0]            blk,
  output logic                        done
);
  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                        busy_q, busy_d;
  logic [KW-1:0]               k_q, k_d;
  logic [ACC_W-1:0]            run_q, run_d, blk_q, blk_d, sum;
  logic [LANES-1:0][ACC_W-1:0] offs_q, offs_d;
  logic                        last;

  assign last = (k_q == KW'(LANES - 1));
  assign sum  = run_q + step;
  assign done = busy_q & last;
  assign offs = offs_q;
  assign blk  = blk_q;

  always_comb begin
    busy_d = busy_q;
    k_d    = k_q;
    run_d  = run_q;
    blk_d  = blk_q;
    offs_d = offs_q;
    // start wins over an in-flight build so a new step restarts cleanly
    if (start) begin
      busy_d = 1'b1;
      k_d    = '0;
      run_d  = '0;
    end else if (busy_q) begin
      offs_d[k_q] = run_q;
      run_d       = sum;
      k_d         = k_q + 1'b1;
      if (last) begin
        blk_d  = sum;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      k_q    <= '0;
      run_q  <= '0;
      blk_q  <= '0;
      offs_q <= '0;
    end else begin
      busy_q <= busy_d;
      k_q    <= k_d;
      run_q  <= run_d;
      blk_q  <= blk_d;
      offs_q <= offs_d;
    end
  end

endmodule

// File: rtl/phase_gen_multi.sv
// LANES-wide M-PSK phase generator on an AXI-Stream master; symbols held SYM_BEATS beats each.
module phase_gen_multi #(
  parameter int              LANES        = 16,
  parameter int              ACC_W        = 32,
  parameter int              OUT_W        = 16,
  parameter int              SYM_W        = 1,
  parameter int              SYM_BEATS    = 4,
  parameter logic [ACC_W-1:0] DEFAULT_STEP = ACC_W'(phase_gen_pkg::DEFAULT_STEP)
) (
  input  logic                   M_AXIS_ACLK,
  input  logic                   M_AXIS_ARESETN,
  output logic                   M_AXIS_TVALID,
  output logic [LANES*OUT_W-1:0] M_AXIS_TDATA,
  input  logic                   M_AXIS_TREADY,
  input  logic                   gen_en,
  input  logic [ACC_W-1:0]       step_in,
  input  logic                   step_load,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  output logic                   sym_underrun
);
  import phase_gen_pkg::*;

  localparam int BW = (SYM_BEATS > 1) ? $clog2(SYM_BEATS) : 1;

  state_e                      state_q, state_d;
  logic [ACC_W-1:0]            acc_q, acc_d, step_q, step_d, pend_step_q, pend_step_d;
  logic                        pend_q, pend_d, start_q, start_d;
  logic                        tvalid_q, tvalid_d, underrun_q, underrun_d;
  logic [SYM_W-1:0]            cur_sym_q, cur_sym_d, nxt_sym;
  logic [BW-1:0]               bcnt_q, bcnt_d;
  logic [LANES-1:0][OUT_W-1:0] tdata_q, tdata_d, lane_ph;
  logic [LANES-1:0][ACC_W-1:0] offs;
  logic [ACC_W-1:0]            blk, acc_nxt, base, sym_ph;
  logic                        done, fire, boundary, sym_take;

  phase_lane_offs #(.LANES(LANES), .ACC_W(ACC_W)) u_offs (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .start (start_q),
    .step  (step_q),
    .offs  (offs),
    .blk   (blk),
    .done  (done)
  );

  assign fire     = tvalid_q & M_AXIS_TREADY;
  assign boundary = (bcnt_q == BW'(SYM_BEATS - 1));
  assign acc_nxt  = acc_q + blk;
  assign sym_take = (state_q == RUN) && fire && boundary && sym_valid;
  assign nxt_sym  = sym_take ? sym_in : cur_sym_q;
  assign sym_ph   = ACC_W'(nxt_sym) << (ACC_W - SYM_W);
  // RUN reloads with the post-fire phase; IDLE presents the retained one
  assign base     = (state_q == RUN) ? acc_nxt : acc_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_ph[i] = OUT_W'(phase_slice(64'(base + offs[i] + sym_ph), ACC_W, OUT_W));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    step_d      = step_q;
    pend_d      = pend_q;
    pend_step_d = pend_step_q;
    start_d     = 1'b0;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    underrun_d  = underrun_q;
    cur_sym_d   = cur_sym_q;
    bcnt_d      = bcnt_q;
    sym_ready   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (step_load) begin
          step_d     = step_in;
          start_d    = 1'b1;
          underrun_d = 1'b0;
        end else if (done && !start_q) begin
          acc_d     = '0;
          bcnt_d    = '0;
          cur_sym_d = sym_valid ? sym_in : '0;
          sym_ready = sym_valid;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        if (step_load) begin
          step_d     = step_in;
          start_d    = 1'b1;
          underrun_d = 1'b0;
          state_d    = LOAD;
        end else if (gen_en) begin
          tvalid_d = 1'b1;
          tdata_d  = lane_ph;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (step_load) begin
          pend_d      = 1'b1;
          pend_step_d = step_in;
          underrun_d  = 1'b0;
        end
        if (fire) begin
          acc_d  = acc_nxt;
          bcnt_d = boundary ? '0 : bcnt_q + 1'b1;
          if (boundary) begin
            if (sym_valid) begin
              cur_sym_d = sym_in;
              sym_ready = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end
          if (step_load || pend_q) begin
            step_d   = step_load ? step_in : pend_step_q;
            pend_d   = 1'b0;
            tvalid_d = 1'b0;
            start_d  = 1'b1;
            state_d  = LOAD;
          end else if (!gen_en) begin
            tvalid_d = 1'b0;
            state_d  = IDLE;
          end else begin
            tdata_d = lane_ph;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q     <= LOAD;
      acc_q       <= '0;
      step_q      <= DEFAULT_STEP;
      pend_q      <= 1'b0;
      pend_step_q <= '0;
      start_q     <= 1'b1;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      underrun_q  <= 1'b0;
      cur_sym_q   <= '0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      pend_step_q <= pend_step_d;
      start_q     <= start_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      underrun_q  <= underrun_d;
      cur_sym_q   <= cur_sym_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign sym_underrun  = underrun_q;

endmodule
